// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU sequencer and instruction decoder:
// opcode map, one-hot state encodings and opcode classification helpers.
package cpu_pkg;

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_STA = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0011;
    localparam logic [3:0] OP_JMP = 4'b0100;
    localparam logic [3:0] OP_JN  = 4'b0101;
    localparam logic [3:0] OP_JZ  = 4'b0110;
    localparam logic [3:0] OP_STP = 4'b0111;
    localparam logic [3:0] OP_OUT = 4'b1000;
    localparam logic [3:0] OP_LSL = 4'b1001;
    localparam logic [3:0] OP_LSR = 4'b1010;

    // One-hot codes seen by the decoder; HALT is the all-zero code.
    typedef enum logic [2:0] {
        ST_HALT  = 3'b000,
        ST_FETCH = 3'b001,
        ST_EXEC1 = 3'b010,
        ST_EXEC2 = 3'b100
    } state_e;

    typedef enum logic {
        MODE_RUN  = 1'b0,
        MODE_STEP = 1'b1
    } mode_e;

    // Instructions that need a second memory access in EXEC2.
    function automatic logic op_needs_exec2(input logic [3:0] op);
        return (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB);
    endfunction

    // Everything above LSR is unassigned.
    function automatic logic op_is_illegal(input logic [3:0] op);
        return (op > OP_LSR);
    endfunction

endpackage

// File: rtl/retire_counter.sv
// Saturating retired-instruction counter with synchronous clear.
module retire_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: clear wins, otherwise increment unless already saturated.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/cpu_sequencer.sv
// Instruction sequencer: HALT/FETCH/EXEC1/EXEC2 control with run and
// single-step modes, stop-at-boundary requests and retirement counting.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             step,
    input  logic             stop_req,
    input  logic [3:0]       opcode,
    input  logic             mem_ready,
    output logic [2:0]       state,
    output logic [3:0]       ir,
    output logic             ir_load,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    state_e     state_q, state_d;
    mode_e      mode_q, mode_d;
    logic       stop_pend_q, stop_pend_d;
    logic [3:0] ir_q, ir_d;
    logic       illegal_q, illegal_d;
    logic       retire_s;
    logic       load_s;
    logic       boundary_halt_s;

    // Next-state logic; a stop_req arriving in the retiring cycle itself still counts.
    always_comb begin
        state_d         = state_q;
        mode_d          = mode_q;
        ir_d            = ir_q;
        illegal_d       = illegal_q;
        retire_s        = 1'b0;
        load_s          = 1'b0;
        boundary_halt_s = (mode_q == MODE_STEP) || stop_pend_q || stop_req;

        case (state_q)
            ST_HALT: begin
                if (start) begin
                    mode_d  = MODE_RUN;
                    state_d = ST_FETCH;
                end else if (step) begin
                    mode_d  = MODE_STEP;
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_HALT;
                end
            end
            ST_FETCH: begin
                if (mem_ready) begin
                    ir_d    = opcode;
                    load_s  = 1'b1;
                    state_d = ST_EXEC1;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_EXEC1: begin
                if (ir_q == OP_STP) begin
                    retire_s = 1'b1;
                    state_d  = ST_HALT;
                end else if (op_needs_exec2(ir_q)) begin
                    state_d = ST_EXEC2;
                end else begin
                    retire_s = 1'b1;
                    if (op_is_illegal(ir_q)) begin
                        illegal_d = 1'b1;
                    end else begin
                        illegal_d = illegal_q;
                    end
                    state_d = boundary_halt_s ? ST_HALT : ST_FETCH;
                end
            end
            ST_EXEC2: begin
                if (mem_ready) begin
                    retire_s = 1'b1;
                    state_d  = boundary_halt_s ? ST_HALT : ST_FETCH;
                end else begin
                    state_d = ST_EXEC2;
                end
            end
            default: begin
                state_d = ST_HALT;
            end
        endcase

        // Pending stop is only collected while running and dropped on reaching HALT.
        if ((state_q == ST_HALT) || (state_d == ST_HALT)) begin
            stop_pend_d = 1'b0;
        end else begin
            stop_pend_d = stop_pend_q || stop_req;
        end
    end

    // Sequencer registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_HALT;
            mode_q      <= MODE_RUN;
            stop_pend_q <= 1'b0;
            ir_q        <= 4'b0000;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            stop_pend_q <= stop_pend_d;
            ir_q        <= ir_d;
            illegal_q   <= illegal_d;
        end
    end

    retire_counter #(
        .CNT_W(CNT_W)
    ) u_retire_counter (
        .clk   (clk),
        .clear (reset),
        .inc   (retire_s),
        .count (retired)
    );

    assign state   = state_q;
    assign halted  = (state_q == ST_HALT);
    assign ir      = ir_q;
    assign ir_load = load_s;
    assign illegal = illegal_q;

endmodule
